// File: rtl/station_array.sv
// station_array: issue-station entries that allocate ops, present ready steps to a scheduler and absorb load data.
// Define STATION_AGE_ORDER_EN to present the oldest-allocated ready entry instead of the lowest-index one.
module station_array #(
    parameter int DEPTH = 4,
    parameter int IOP_W = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             a_rst_n,
    input  logic             id_feed,
    input  logic [IOP_W-1:0] id_iop,
    input  logic [2:0]       id_iop_init,
    input  logic [15:0]      id_pc,
    input  logic [15:0]      id_k16,
    output logic             id_ready,
    output logic [IDX_W-1:0] id_idx,
    input  logic             lsu_wb,
    input  logic [IDX_W-1:0] lsu_tag,
    input  logic [15:0]      lsu_data,
    output logic             r_valid,
    output logic [IDX_W-1:0] r_idx,
    output logic [2:0]       r_step,
    output logic [IOP_W-1:0] r_iop,
    output logic [15:0]      r_pc,
    output logic [15:0]      r_k16,
    output logic [IDX_W:0]   r_count,
    input  logic             sched_ack
);
    localparam int CW = IDX_W + 1;

    // Ready states carry their step code, so bit 2 alone marks an entry as ready.
    typedef enum logic [2:0] {
        FREE  = 3'b000,
        WAIT0 = 3'b001,
        WAIT1 = 3'b010,
        LOAD0 = 3'b100,
        LOAD1 = 3'b101,
        ALU   = 3'b110,
        STORE = 3'b111
    } state_t;

    state_t           st  [DEPTH];
    logic [IOP_W-1:0] iop [DEPTH];
    logic [15:0]      pc  [DEPTH];
    logic [15:0]      k16 [DEPTH];
    logic [DEPTH-1:0] rdy, free;
    logic [IDX_W-1:0] sel;
    logic             alloc, ack;

    function automatic state_t adv(input state_t s, input logic [IOP_W-1:0] w);
        return s == LOAD0 ? WAIT0 :
               s == LOAD1 ? (w[4] ? FREE : WAIT1) :
               s == ALU   ? (w[23] ? STORE : FREE) : FREE;
    endfunction

    always_comb begin
        id_idx  = '0;
        r_count = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i]  = st[i][2];
            free[i] = st[i] == FREE;
            if (free[i]) id_idx = IDX_W'(i);
            r_count = r_count + CW'(!free[i]);
        end
    end

`ifdef STATION_AGE_ORDER_EN
    // older[i][j] set: entry i was allocated before entry j.
    logic [DEPTH-1:0] older [DEPTH];
    logic [DEPTH-1:0] win;

    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            win[i] = rdy[i];
            for (int j = 0; j < DEPTH; j++)
                if (j != i && rdy[j] && !older[i][j]) win[i] = 1'b0;
            if (win[i]) sel = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else if (alloc) begin
            for (int i = 0; i < DEPTH; i++)
                for (int j = 0; j < DEPTH; j++)
                    if (IDX_W'(i) == id_idx) older[i][j] <= 1'b0;
                    else if (IDX_W'(j) == id_idx) older[i][j] <= 1'b1;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (rdy[i]) sel = IDX_W'(i);
    end
`endif

    assign id_ready = |free;
    assign alloc    = id_feed & id_ready;
    assign r_valid  = |rdy;
    assign ack      = r_valid & sched_ack;
    assign r_idx    = sel;
    assign r_step   = r_valid ? st[sel]  : 3'b000;
    assign r_iop    = r_valid ? iop[sel] : '0;
    assign r_pc     = r_valid ? pc[sel]  : '0;
    assign r_k16    = r_valid ? k16[sel] : '0;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                st[i]  <= FREE;
                iop[i] <= '0;
                pc[i]  <= '0;
                k16[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc && id_idx == IDX_W'(i)) begin
                    st[i]  <= state_t'(id_iop_init);
                    iop[i] <= id_iop;
                    pc[i]  <= id_pc;
                    k16[i] <= id_k16;
                end else if (ack && sel == IDX_W'(i)) begin
                    st[i] <= adv(st[i], iop[i]);
                end else if (lsu_wb && lsu_tag == IDX_W'(i) && (st[i] == WAIT0 || st[i] == WAIT1)) begin
                    st[i]  <= st[i] == WAIT0 ? LOAD1 : ALU;
                    k16[i] <= lsu_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_station_array.sv
// tb_station_array: vector table, hand-written corner sequences and a random run against a queue-based reference model.
module tb_station_array;
    localparam int DEPTH = 4;
    localparam int IOP_W = 32;
    localparam int IDX_W = 2;
    // Model state codes: ready states use their step code, the rest are private.
    localparam int F = 0, W0 = 8, W1 = 9;

    logic             clk = 1'b0;
    logic             a_rst_n = 1'b0;
    logic             id_feed, lsu_wb, sched_ack;
    logic [IOP_W-1:0] id_iop;
    logic [2:0]       id_iop_init;
    logic [15:0]      id_pc, id_k16, lsu_data;
    logic [IDX_W-1:0] lsu_tag;
    logic             id_ready, r_valid;
    logic [IDX_W-1:0] id_idx, r_idx;
    logic [2:0]       r_step;
    logic [IOP_W-1:0] r_iop;
    logic [15:0]      r_pc, r_k16;
    logic [IDX_W:0]   r_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    station_array #(.DEPTH(DEPTH), .IOP_W(IOP_W)) dut (
        .clk(clk), .a_rst_n(a_rst_n),
        .id_feed(id_feed), .id_iop(id_iop), .id_iop_init(id_iop_init), .id_pc(id_pc), .id_k16(id_k16),
        .id_ready(id_ready), .id_idx(id_idx),
        .lsu_wb(lsu_wb), .lsu_tag(lsu_tag), .lsu_data(lsu_data),
        .r_valid(r_valid), .r_idx(r_idx), .r_step(r_step), .r_iop(r_iop), .r_pc(r_pc), .r_k16(r_k16),
        .r_count(r_count), .sched_ack(sched_ack)
    );

    typedef struct {
        logic        feed;
        logic [2:0]  init;
        logic [31:0] iop;
        logic [15:0] pc;
        logic [15:0] k;
        logic        wb;
        logic [1:0]  tag;
        logic [15:0] data;
        logic        ack;
        logic        e_ready;
        logic [1:0]  e_idx;
        logic        e_valid;
        logic [1:0]  e_ridx;
        logic [2:0]  e_step;
        logic [15:0] e_k;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t tbl [15];

    int               m_st  [DEPTH];
    logic [31:0]      m_iop [DEPTH];
    logic [15:0]      m_pc  [DEPTH];
    logic [15:0]      m_k   [DEPTH];
    int               order [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic feed, input logic [2:0] init, input logic [31:0] iop,
                         input logic [15:0] pc, input logic [15:0] k, input logic wb,
                         input logic [1:0] tag, input logic [15:0] data, input logic ack);
        id_feed = feed; id_iop_init = init; id_iop = iop; id_pc = pc; id_k16 = k;
        lsu_wb = wb; lsu_tag = tag; lsu_data = data; sched_ack = ack;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 32'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        a_rst_n = 1'b0;
        tick();
        a_rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            m_st[i] = F; m_iop[i] = '0; m_pc[i] = '0; m_k[i] = '0;
        end
        order.delete();
    endtask

    function automatic bit is_rdy(input int s);
        return s >= 4 && s <= 7;
    endfunction

    function automatic int m_sel();
`ifdef STATION_AGE_ORDER_EN
        foreach (order[k]) if (is_rdy(m_st[order[k]])) return order[k];
`else
        for (int i = 0; i < DEPTH; i++) if (is_rdy(m_st[i])) return i;
`endif
        return -1;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < DEPTH; i++) if (m_st[i] == F) return i;
        return -1;
    endfunction

    initial begin
        int s, f, cnt, pre;
        logic feed, wb, ack;
        logic [2:0] init;
        logic [31:0] iop;
        logic [15:0] pc, k, data;
        logic [1:0] tag;

        // feed init iop pc k | wb tag data | ack || ready idx valid ridx step k16 count
        tbl[0]  = '{1'b1, 3'b110, 32'h0000_0100, 16'h0010, 16'h0005, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 16'h0000, 3'd0};
        tbl[1]  = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 3'b110, 16'h0005, 3'd1};
        tbl[2]  = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 16'h0000, 3'd0};
        tbl[3]  = '{1'b1, 3'b100, 32'h0000_0000, 16'h0020, 16'h0007, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 16'h0000, 3'd0};
        tbl[4]  = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 3'b100, 16'h0007, 3'd1};
        tbl[5]  = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'h1234, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 3'b000, 16'h0000, 3'd1};
        tbl[6]  = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 3'b101, 16'h1234, 3'd1};
        tbl[7]  = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b1, 2'd0, 16'hBEEF, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 3'b000, 16'h0000, 3'd1};
        tbl[8]  = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 3'b110, 16'hBEEF, 3'd1};
        tbl[9]  = '{1'b1, 3'b110, 32'h0080_0000, 16'h0030, 16'h0003, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 16'h0000, 3'd0};
        tbl[10] = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 3'b110, 16'h0003, 3'd1};
        tbl[11] = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 3'b111, 16'h0003, 3'd1};
        tbl[12] = '{1'b1, 3'b101, 32'h0000_0010, 16'h0040, 16'h0009, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 16'h0000, 3'd0};
        tbl[13] = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b1, 2'd1, 1'b1, 2'd0, 3'b101, 16'h0009, 3'd1};
        tbl[14] = '{1'b0, 3'b000, 32'h0000_0000, 16'h0000, 16'h0000, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 2'd0, 3'b000, 16'h0000, 3'd0};

        idle();
        #2;
        chk("reset id_ready", id_ready, 1);
        chk("reset r_valid", r_valid, 0);
        chk("reset r_count", r_count, 0);
        do_reset();

        for (int n = 0; n < 15; n++) begin
            drive(tbl[n].feed, tbl[n].init, tbl[n].iop, tbl[n].pc, tbl[n].k,
                  tbl[n].wb, tbl[n].tag, tbl[n].data, tbl[n].ack);
            #1;
            chk($sformatf("vec%0d id_ready", n), id_ready, tbl[n].e_ready);
            chk($sformatf("vec%0d id_idx", n), id_idx, tbl[n].e_idx);
            chk($sformatf("vec%0d r_valid", n), r_valid, tbl[n].e_valid);
            chk($sformatf("vec%0d r_idx", n), r_idx, tbl[n].e_ridx);
            chk($sformatf("vec%0d r_step", n), r_step, tbl[n].e_step);
            chk($sformatf("vec%0d r_k16", n), r_k16, tbl[n].e_k);
            chk($sformatf("vec%0d r_count", n), r_count, tbl[n].e_cnt);
            tick();
        end

        // Full array: further feeds ignored, a freed slot reappears only after the edge.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 3'b110, 32'h0, 16'h0, 16'(i), 1'b0, 2'd0, 16'h0, 1'b0);
            #1;
            chk("fill id_idx", id_idx, i);
            tick();
        end
        idle();
        #1;
        chk("full id_ready", id_ready, 0);
        chk("full r_count", r_count, 4);
        drive(1'b1, 3'b110, 32'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0);
        tick();
        chk("full feed ignored", r_count, 4);
        drive(1'b1, 3'b110, 32'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b1);
        #1;
        chk("ack cycle id_ready", id_ready, 0);
        tick();
        idle();
        #1;
        chk("after free id_ready", id_ready, 1);
        chk("after free id_idx", id_idx, 0);
        chk("after free r_count", r_count, 3);

        // Entry 2 reallocated before entry 0; selection order then depends on the age option.
        do_reset();
        drive(1'b1, 3'b100, 32'h10, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0); tick();
        drive(1'b1, 3'b100, 32'h10, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0); tick();
        drive(1'b1, 3'b110, 32'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b0); tick();
        drive(1'b0, 3'b000, 32'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b1);
        tick(); tick(); tick();
        drive(1'b1, 3'b110, 32'h0, 16'h0, 16'h00A2, 1'b0, 2'd0, 16'h0, 1'b0);
        #1;
        chk("age alloc idx2", id_idx, 2);
        tick();
        drive(1'b0, 3'b000, 32'h0, 16'h0, 16'h0, 1'b1, 2'd0, 16'h0001, 1'b0); tick();
        drive(1'b0, 3'b000, 32'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b1);
        #1;
        chk("age free e0 r_idx", r_idx, 0);
        tick();
        drive(1'b1, 3'b110, 32'h0, 16'h0, 16'h00A0, 1'b0, 2'd0, 16'h0, 1'b0);
        #1;
        chk("age alloc idx0", id_idx, 0);
        tick();
        idle();
        #1;
`ifdef STATION_AGE_ORDER_EN
        chk("age pick r_idx", r_idx, 2);
        chk("age pick r_k16", r_k16, 16'h00A2);
`else
        chk("age pick r_idx", r_idx, 0);
        chk("age pick r_k16", r_k16, 16'h00A0);
`endif

        // Writeback to an ALU entry is ignored; async reset clears everything at once.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b110, 32'h0, 16'h0, 16'h1110 + 16'(i), 1'b0, 2'd0, 16'h0, 1'b0);
            tick();
        end
        drive(1'b0, 3'b000, 32'h0, 16'h0, 16'h0, 1'b1, 2'd1, 16'h5555, 1'b0); tick();
        drive(1'b0, 3'b000, 32'h0, 16'h0, 16'h0, 1'b0, 2'd0, 16'h0, 1'b1); tick();
        idle();
        #1;
        chk("wb ignored r_idx", r_idx, 1);
        chk("wb ignored r_step", r_step, 3'b110);
        chk("wb ignored r_k16", r_k16, 16'h1111);
        drive(1'b1, 3'b110, 32'hFFFF_FFFF, 16'hFFFF, 16'h1113, 1'b0, 2'd0, 16'h0, 1'b0); tick();
        idle();
        #1;
        chk("busy r_count", r_count, 3);
        #1;
        a_rst_n = 1'b0;
        #1;
        chk("async r_count", r_count, 0);
        chk("async r_valid", r_valid, 0);
        chk("async id_ready", id_ready, 1);
        chk("async id_idx", id_idx, 0);
        chk("async r_idx", r_idx, 0);
        chk("async r_step", r_step, 0);
        chk("async r_iop", r_iop, 0);
        chk("async r_pc", r_pc, 0);
        chk("async r_k16", r_k16, 0);
        @(negedge clk);
        a_rst_n = 1'b1;
        drive(1'b0, 3'b000, 32'h0, 16'h0, 16'h0, 1'b1, 2'd1, 16'h7777, 1'b0);
        tick();
        idle();
        #1;
        chk("post reset wb r_count", r_count, 0);
        chk("post reset wb r_valid", r_valid, 0);

        // Random traffic against the reference model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            feed = $urandom_range(0, 9) < 4;
            init = {1'b1, 2'($urandom_range(0, 3))};
            iop  = $urandom;
            pc   = 16'($urandom);
            k    = 16'($urandom);
            wb   = $urandom_range(0, 1) == 1;
            tag  = 2'($urandom_range(0, 3));
            data = 16'($urandom);
            ack  = $urandom_range(0, 9) < 6;
            drive(feed, init, iop, pc, k, wb, tag, data, ack);
            #1;
            s = m_sel();
            f = m_free();
            cnt = 0;
            for (int i = 0; i < DEPTH; i++) if (m_st[i] != F) cnt++;
            chk("rnd id_ready", id_ready, f >= 0);
            chk("rnd id_idx", id_idx, f >= 0 ? f : 0);
            chk("rnd r_valid", r_valid, s >= 0);
            chk("rnd r_idx", r_idx, s >= 0 ? s : 0);
            chk("rnd r_step", r_step, s >= 0 ? m_st[s] : 0);
            chk("rnd r_iop", r_iop, s >= 0 ? m_iop[s] : 0);
            chk("rnd r_pc", r_pc, s >= 0 ? m_pc[s] : 0);
            chk("rnd r_k16", r_k16, s >= 0 ? m_k[s] : 0);
            chk("rnd r_count", r_count, cnt);
            pre = m_st[tag];
            if (ack && s >= 0) begin
                case (m_st[s])
                    4: m_st[s] = W0;
                    5: m_st[s] = m_iop[s][4] ? F : W1;
                    6: m_st[s] = m_iop[s][23] ? 7 : F;
                    default: m_st[s] = F;
                endcase
                if (m_st[s] == F)
                    for (int q = 0; q < order.size(); q++)
                        if (order[q] == s) begin
                            order.delete(q);
                            break;
                        end
            end
            if (wb && (pre == W0 || pre == W1)) begin
                m_st[tag] = pre == W0 ? 5 : 6;
                m_k[tag]  = data;
            end
            if (feed && f >= 0) begin
                m_st[f] = int'(init);
                m_iop[f] = iop;
                m_pc[f] = pc;
                m_k[f] = k;
                order.push_back(f);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
